bcd_conv_sched: RTL and testbench
=================================

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port `CLOCK_50`, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-003 Port `Resetn`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `req_a`, input, 1 bit: requester A conversion request (level).
REQ-005 Port `val_a`, input, 6 bits: requester A binary operand, 0..63.
REQ-006 Port `req_b`, input, 1 bit: requester B conversion request (level).
REQ-007 Port `val_b`, input, 6 bits: requester B binary operand, 0..63.
REQ-008 Port `ack_a`, output, 1 bit: one-cycle pulse, A's request accepted; `ack_b` SHALL behave the same for B.
REQ-009 Port `done_a`, output, 1 bit: one-cycle pulse, A's result registers updated; `done_b` SHALL behave the same for B.
REQ-010 Port `tens_a` and port `ones_a`, outputs, 4 bits each: A's BCD result, held until overwritten; `tens_b` and `ones_b` SHALL behave the same for B.
REQ-011 Port `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and CONV, plus a shared datapath: 6-bit `rem`, 4-bit `tcnt`, 1-bit `sel` (granted channel) and 1-bit `last` (last channel served).
REQ-013 Arbitration in IDLE:
- Only one req high: grant that channel.
- Both high: grant the channel not equal to `last` (round-robin).
- Neither high: stay in IDLE.
REQ-014 On a granting edge in IDLE, the block SHALL:
- set `rem` to the granted val and `tcnt` to 0;
- set `sel` to the granted channel;
- enter CONV;
- assert the granted channel's ack for exactly the following cycle.
REQ-015 In CONV with `rem` >= 10, each edge SHALL subtract 10 from `rem` and add 1 to `tcnt`.
REQ-016 In CONV with `rem` < 10, the edge SHALL:
- write `tcnt` to the `sel` channel's tens register and `rem[3:0]` to its ones register;
- pulse that channel's done for one cycle;
- set `last` to `sel`;
- return to IDLE.
REQ-017 For operand v, ack SHALL be high in the cycle after the sampling edge, and done SHALL be high in the cycle after edge floor(v/10)+1 counted from the sampling edge: 1 edge for v=0..9, up to 7 edges for v=63.
REQ-018 The val inputs SHALL be sampled only on the granting edge; changes on the val inputs during CONV SHALL have no effect.
REQ-019 A req still high in the first IDLE cycle after done SHALL be treated as a new request; a requester SHALL drop req in the cycle in which it sees its ack.
REQ-020 A req arriving during CONV SHALL wait and be arbitrated on the next IDLE cycle; no request SHALL be lost while its req stays high.
REQ-021 The non-selected channel's result registers and done SHALL remain unchanged during a conversion.
REQ-022 At most one ack and at most one done SHALL be high in any cycle.
REQ-023 The minimum period between successive grants SHALL be one IDLE cycle, so back-to-back requests alternate channels with no starvation.

Reset
REQ-024 While `Resetn` = 0, the block SHALL immediately and asynchronously force:
- state = IDLE;
- `rem`, `tcnt`, `sel` = 0;
- `last` = B, so A wins the first contention;
- all ack and done outputs = 0;
- `busy` = 0;
- all tens and ones outputs = 0.
REQ-025 Reset asserted during CONV SHALL abort the conversion, producing no done pulse and no update to the result registers.
REQ-026 After `Resetn` rises, the first rising edge SHALL perform normal IDLE arbitration.

Verification
REQ-027 Single request: A requests with v=0 -> `ack_a` is high one cycle, `done_a` is high 1 edge after the sampling edge, `tens_a`=0, `ones_a`=0.
REQ-028 Maximum value: B requests with v=63 -> `done_b` is high 7 edges after the sampling edge, `tens_b`=6, `ones_b`=3, and A's outputs are unchanged.
REQ-029 Contention: after reset, A (v=25) and B (v=47) request together and both hold req -> A is served first (2,5), then B (4,7), and the channels alternate thereafter.
REQ-030 Operand change: `val_a` changes from 37 to 12 one cycle after `ack_a` -> the result is 3,7.
REQ-031 Reset mid-operation: `Resetn` is pulsed low during CONV for v=58 -> no `done_a`, all outputs read 0, and the next request proceeds normally.
REQ-032 Exhaustive sweep: A steps through v=0..63 -> every `tens_a`*10+`ones_a` equals v, and every done latency equals floor(v/10)+1.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - two-requester round-robin binary-to-BCD converter (0..63)
module bcd_conv_sched (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       req_a,
    input  logic [5:0] val_a,
    input  logic       req_b,
    input  logic [5:0] val_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       done_a,
    output logic       done_b,
    output logic [3:0] tens_a,
    output logic [3:0] ones_a,
    output logic [3:0] tens_b,
    output logic [3:0] ones_b,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    // Channel encoding used by sel/last: 0 = requester A, 1 = requester B.
    state_t     state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;
    logic       done_a_q, done_a_d;
    logic       done_b_q, done_b_d;
    logic [3:0] tens_a_q, tens_a_d;
    logic [3:0] ones_a_q, ones_a_d;
    logic [3:0] tens_b_q, tens_b_d;
    logic [3:0] ones_b_q, ones_b_d;
    logic       grant;

    // Arbitration, repeated-subtraction conversion and result write-back.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tcnt_d   = tcnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        tens_a_d = tens_a_q;
        ones_a_d = ones_a_q;
        tens_b_d = tens_b_q;
        ones_b_d = ones_b_q;
        grant    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // Under contention the channel not served last wins.
                    grant   = (req_a && req_b) ? ~last_q : req_b;
                    rem_d   = grant ? val_b : val_a;
                    tcnt_d  = 4'd0;
                    sel_d   = grant;
                    state_d = CONV;
                    ack_a_d = ~grant;
                    ack_b_d = grant;
                end
            end
            CONV: begin
                if (rem_q >= 6'd10) begin
                    rem_d  = rem_q - 6'd10;
                    tcnt_d = tcnt_q + 4'd1;
                end else begin
                    if (sel_q) begin
                        tens_b_d = tcnt_q;
                        ones_b_d = rem_q[3:0];
                        done_b_d = 1'b1;
                    end else begin
                        tens_a_d = tcnt_q;
                        ones_a_d = rem_q[3:0];
                        done_a_d = 1'b1;
                    end
                    last_d  = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last resets to B so A wins first contention.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            rem_q    <= 6'd0;
            tcnt_q   <= 4'd0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            tens_a_q <= 4'd0;
            ones_a_q <= 4'd0;
            tens_b_q <= 4'd0;
            ones_b_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tcnt_q   <= tcnt_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            tens_a_q <= tens_a_d;
            ones_a_q <= ones_a_d;
            tens_b_q <= tens_b_d;
            ones_b_q <= ones_b_d;
        end
    end

    assign ack_a  = ack_a_q;
    assign ack_b  = ack_b_q;
    assign done_a = done_a_q;
    assign done_b = done_b_q;
    assign tens_a = tens_a_q;
    assign ones_a = ones_a_q;
    assign tens_b = tens_b_q;
    assign ones_b = ones_b_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - scoreboard bench for bcd_conv_sched
module tb_bcd_conv_sched;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       req_a    = 1'b0;
    logic       req_b    = 1'b0;
    logic [5:0] val_a    = 6'd0;
    logic [5:0] val_b    = 6'd0;
    logic       ack_a, ack_b, done_a, done_b, busy;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;

    bcd_conv_sched dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .req_a    (req_a),
        .val_a    (val_a),
        .req_b    (req_b),
        .val_b    (val_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .done_a   (done_a),
        .done_b   (done_b),
        .tens_a   (tens_a),
        .ones_a   (ones_a),
        .tens_b   (tens_b),
        .ones_b   (ones_b),
        .busy     (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int ch;
        int tens;
        int ones;
        int lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cyc[2];
    int   held_t[2];
    int   held_o[2];
    int   dch;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_lit(input int ch, input int t, input int o, input int lat);
        exp_t x;
        x.ch = ch; x.tens = t; x.ones = o; x.lat = lat;
        q.push_back(x);
    endtask

    // Raise the requested reqs, drop each on its ack, return after need dones.
    task automatic drive(input bit ra, input bit rb, input int va, input int vb, input int need);
        int got;
        got   = 0;
        val_a = 6'(va);
        val_b = 6'(vb);
        req_a = ra;
        req_b = rb;
        for (int i = 0; i < 200 && got < need; i++) begin
            @(negedge CLOCK_50);
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
            if (done_a || done_b) got++;
        end
        if (got < need) chk("drive_timeout", got, need);
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge CLOCK_50) begin
        if (ack_a || ack_b) begin
            chk("ack_onehot", int'(ack_a && ack_b), 0);
            chk("busy_in_conv", int'(busy), 1);
            if (ack_a) ack_cyc[0] = cyc;
            if (ack_b) ack_cyc[1] = cyc;
        end
        if (done_a || done_b) begin
            chk("done_onehot", int'(done_a && done_b), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done_a=%0d done_b=%0d required none", done_a, done_b);
            end else begin
                e   = q.pop_front();
                dch = done_b ? 1 : 0;
                chk("done_channel", dch, e.ch);
                if (dch == 0) begin
                    chk("tens_a", int'(tens_a), e.tens);
                    chk("ones_a", int'(ones_a), e.ones);
                    chk("held_tens_b", int'(tens_b), held_t[1]);
                    chk("held_ones_b", int'(ones_b), held_o[1]);
                end else begin
                    chk("tens_b", int'(tens_b), e.tens);
                    chk("ones_b", int'(ones_b), e.ones);
                    chk("held_tens_a", int'(tens_a), held_t[0]);
                    chk("held_ones_a", int'(ones_a), held_o[0]);
                end
                chk("done_latency", cyc - ack_cyc[dch], e.lat);
                held_t[e.ch] = e.tens;
                held_o[e.ch] = e.ones;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_acks"},   int'({ack_a, ack_b}), 0);
        chk({tag, "_dones"},  int'({done_a, done_b}), 0);
        chk({tag, "_tens_a"}, int'(tens_a), 0);
        chk({tag, "_ones_a"}, int'(ones_a), 0);
        chk({tag, "_tens_b"}, int'(tens_b), 0);
        chk({tag, "_ones_b"}, int'(ones_b), 0);
    endtask

    initial begin
        int waited;
        held_t[0] = 0; held_t[1] = 0; held_o[0] = 0; held_o[1] = 0;
        ack_cyc[0] = 0; ack_cyc[1] = 0;
        #5;
        chk_all_zero("reset");
        repeat (2) @(negedge CLOCK_50);
        Resetn = 1'b1;

        // Single request, v=0
        push_lit(0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);

        // Maximum value on B
        push_lit(1, 6, 3, 7);
        drive(0, 1, 0, 63, 1);

        // Fresh reset, then contention A=25, B=47, then alternation
        @(posedge CLOCK_50); #2 Resetn = 1'b0;
        held_t[0] = 0; held_t[1] = 0; held_o[0] = 0; held_o[1] = 0;
        #1 chk_all_zero("reset2");
        @(negedge CLOCK_50); Resetn = 1'b1;
        push_lit(0, 2, 5, 3);
        push_lit(1, 4, 7, 5);
        drive(1, 1, 25, 47, 2);
        push_lit(0, 1, 8, 2);
        push_lit(1, 0, 3, 1);
        drive(1, 1, 18, 3, 2);
        push_lit(0, 6, 0, 7);
        push_lit(1, 5, 9, 6);
        drive(1, 1, 60, 59, 2);

        // Operand change after ack: 37 then 12 -> result 3,7
        push_lit(0, 3, 7, 4);
        val_a = 6'd37;
        req_a = 1'b1;
        waited = 0;
        do begin
            @(negedge CLOCK_50);
            waited++;
        end while (!ack_a && waited < 50);
        chk("opchg_ack_seen", int'(ack_a), 1);
        req_a = 1'b0;
        @(negedge CLOCK_50);
        val_a = 6'd12;
        waited = 0;
        while (!done_a && waited < 50) begin
            @(negedge CLOCK_50);
            waited++;
        end
        chk("opchg_done_seen", int'(done_a), 1);

        // Reset in the middle of a v=58 conversion
        val_a = 6'd58;
        req_a = 1'b1;
        waited = 0;
        do begin
            @(negedge CLOCK_50);
            waited++;
        end while (!ack_a && waited < 50);
        chk("rst_ack_seen", int'(ack_a), 1);
        req_a = 1'b0;
        @(posedge CLOCK_50); #2 Resetn = 1'b0;
        held_t[0] = 0; held_t[1] = 0; held_o[0] = 0; held_o[1] = 0;
        #1 chk_all_zero("midreset");
        @(negedge CLOCK_50); Resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        chk_all_zero("after_abort");
        push_lit(0, 5, 8, 6);
        drive(1, 0, 58, 0, 1);

        // Sweep A over the full operand range
        for (int v = 0; v < 64; v++) begin
            push_lit(0, v / 10, v % 10, v / 10 + 1);
            drive(1, 0, v, 0, 1);
        end

        repeat (5) @(negedge CLOCK_50);
        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
